// File: rtl/ft245_sched_pkg.sv
// Shared definitions for the FT245 bus scheduler.
//   MAX_BURST_DEFAULT : bytes per bus grant before forced re-arbitration
//   CNT_W             : width of the burst counter
//   sched_state_t     : scheduler FSM state encoding
package ft245_sched_pkg;

  localparam int MAX_BURST_DEFAULT = 64;
  localparam int CNT_W             = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_OE = 3'd1,
    RD    = 3'd2,
    WR    = 3'd3,
    TURN  = 3'd4
  } sched_state_t;

endpackage

// File: rtl/ft245_bus_sched.sv
// FT245 asynchronous-FIFO bus scheduler.
// Arbitrates the shared FT245 data bus between the RX path (FT245 -> RxData)
// and the TX path (TxData -> FT245), round-robin when both want the bus, with
// at most MAX_BURST bytes per grant and one turnaround cycle between grants.
//
// State table:
//   IDLE  | strobes idle, bus released; arbitration between rx and tx requests
//   RD_OE | FT245 output enable asserted one cycle before the first read strobe
//   RD    | read burst; RDn follows ~RxReady, one byte per edge with RDn=RXFn=0
//   WR    | write burst; block drives DOut, one byte per edge with TxReady=1
//   TURN  | all strobes high, bus released for one cycle before re-arbitration
//
// Ports:
//   Clk, ARst        clock (rising edge), asynchronous active-high reset
//   RXFn, TXEn       FT245 RX not-empty / TX not-full flags (active-low)
//   RDn, WRn, OEn    FT245 read strobe / write strobe / output enable (active-low)
//   DIn, DOut        bus data from / to the FT245
//   DOutEn           high while this block drives the bus
//   RxData, RxValid  received byte and its single-cycle valid strobe
//   RxReady          downstream can take a byte next cycle
//   TxData, TxValid  byte to transmit and its valid
//   TxReady          TxData consumed this cycle
module ft245_bus_sched
  import ft245_sched_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic       Clk,
  input  logic       ARst,
  input  logic       RXFn,
  input  logic       TXEn,
  output logic       RDn,
  output logic       WRn,
  output logic       OEn,
  input  logic [7:0] DIn,
  output logic [7:0] DOut,
  output logic       DOutEn,
  output logic [7:0] RxData,
  output logic       RxValid,
  input  logic       RxReady,
  input  logic [7:0] TxData,
  input  logic       TxValid,
  output logic       TxReady
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  sched_state_t     state, state_nxt;
  logic [CNT_W-1:0] count;
  logic             last_rx;

  logic rx_req, tx_req;
  logic rd_xfer, wr_xfer;
  logic last_xfer;
  logic grant;

  assign rx_req    = ~RXFn & RxReady;
  assign tx_req    = ~TXEn & TxValid;
  assign rd_xfer   = (state == RD) & RxReady & ~RXFn;
  assign wr_xfer   = (state == WR) & TxValid & ~TXEn;
  // The transfer happening this cycle brings the counter to MAX_BURST.
  assign last_xfer = (count == MAX_CNT - 8'd1);
  assign grant     = (state == IDLE) & (state_nxt != IDLE);

  always_ff @(posedge Clk or posedge ARst) begin
    if (ARst) begin
      state   <= IDLE;
      count   <= '0;
      last_rx <= 1'b0;
      RxData  <= 8'h00;
      RxValid <= 1'b0;
    end else begin
      state   <= state_nxt;
      RxValid <= rd_xfer;
      if (rd_xfer) begin
        RxData <= DIn;
      end
      if (grant) begin
        count   <= '0;
        last_rx <= (state_nxt == RD_OE);
      end else if ((rd_xfer || wr_xfer) && (count != MAX_CNT)) begin
        count <= count + 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    RDn       = 1'b1;
    WRn       = 1'b1;
    OEn       = 1'b1;
    DOutEn    = 1'b0;
    DOut      = 8'h00;
    TxReady   = 1'b0;
    case (state)
      IDLE: begin
        // Both pending: hand the bus to the side that did not have it last.
        if (rx_req && tx_req) begin
          state_nxt = last_rx ? WR : RD_OE;
        end else if (rx_req) begin
          state_nxt = RD_OE;
        end else if (tx_req) begin
          state_nxt = WR;
        end
      end
      RD_OE: begin
        OEn       = 1'b0;
        state_nxt = RD;
      end
      RD: begin
        OEn = 1'b0;
        RDn = ~RxReady;
        if (RXFn || !RxReady || (rd_xfer && last_xfer)) begin
          state_nxt = TURN;
        end
      end
      WR: begin
        DOutEn  = 1'b1;
        DOut    = TxData;
        WRn     = ~TxValid;
        TxReady = TxValid & ~TXEn;
        if (!TxValid || TXEn || (wr_xfer && last_xfer)) begin
          state_nxt = TURN;
        end
      end
      TURN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ft245_bus_sched.sv
// Directed bench for ft245_bus_sched with a small FT245 FIFO model and
// byte scoreboards for both directions.
module tb_ft245_bus_sched;
  import ft245_sched_pkg::*;

  localparam int MB = 4;

  logic       Clk = 1'b0;
  logic       ARst, RXFn, TXEn, RDn, WRn, OEn, DOutEn;
  logic       RxValid, RxReady, TxValid, TxReady;
  logic [7:0] DIn, DOut, RxData, TxData;

  int errors = 0;
  int checks = 0;

  logic [7:0] rx_fifo[$];
  logic [7:0] rx_exp[$];
  logic [7:0] tx_src[$];
  logic [7:0] tx_exp[$];
  int         grant_log[$];
  int         burst_log[$];
  int rd_cnt, wr_cnt, rxv_cnt, wrn_low_cnt, txr_cnt, xfer_cnt;

  always #5 Clk = ~Clk;

  ft245_bus_sched #(.MAX_BURST(MB)) dut (
    .Clk(Clk), .ARst(ARst), .RXFn(RXFn), .TXEn(TXEn),
    .RDn(RDn), .WRn(WRn), .OEn(OEn),
    .DIn(DIn), .DOut(DOut), .DOutEn(DOutEn),
    .RxData(RxData), .RxValid(RxValid), .RxReady(RxReady),
    .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    RXFn    = (rx_fifo.size() == 0);
    DIn     = (rx_fifo.size() != 0) ? rx_fifo[0] : 8'h00;
    TxValid = (tx_src.size() != 0);
    TxData  = (tx_src.size() != 0) ? tx_src[0] : 8'h00;
  endtask

  task automatic load_rx(input logic [7:0] b);
    rx_fifo.push_back(b);
    rx_exp.push_back(b);
  endtask

  task automatic load_tx(input logic [7:0] b);
    tx_src.push_back(b);
    tx_exp.push_back(b);
  endtask

  task automatic clear_stats();
    rd_cnt = 0; wr_cnt = 0; rxv_cnt = 0; wrn_low_cnt = 0; txr_cnt = 0; xfer_cnt = 0;
    grant_log.delete();
    burst_log.delete();
  endtask

  // One clock: sample strobes before the edge, advance the FIFO model after it.
  task automatic tick();
    logic         rd_pre, wr_pre;
    sched_state_t pre_st, post_st;
    logic [7:0]   e;
    #1;
    pre_st = dut.state;
    rd_pre = (RDn === 1'b0) && (RXFn === 1'b0);
    wr_pre = (WRn === 1'b0) && (TxReady === 1'b1);
    check("rdn_wrn_excl", 32'(!(RDn === 1'b0 && WRn === 1'b0)), 32'd1);
    check("rdn_only_rd",  32'(!(RDn === 1'b0 && pre_st != RD)), 32'd1);
    check("wrn_only_wr",  32'(!(WRn === 1'b0 && pre_st != WR)), 32'd1);
    check("douten_wr",    32'(DOutEn), 32'(pre_st == WR));
    check("oe_douten",    32'(!(DOutEn === 1'b1 && OEn === 1'b0)), 32'd1);
    if (WRn === 1'b0) wrn_low_cnt++;
    if (TxReady === 1'b1) txr_cnt++;
    if (wr_pre) begin
      if (tx_exp.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
      else begin
        e = tx_exp.pop_front();
        check("tx_byte", 32'(DOut), 32'(e));
      end
      wr_cnt++;
      xfer_cnt++;
    end
    if (rd_pre) begin
      rd_cnt++;
      xfer_cnt++;
    end
    @(posedge Clk);
    #1;
    post_st = dut.state;
    if (rd_pre) void'(rx_fifo.pop_front());
    if (wr_pre) void'(tx_src.pop_front());
    drive();
    check("rxvalid_latency", 32'(RxValid), 32'(rd_pre));
    if (RxValid === 1'b1) begin
      rxv_cnt++;
      if (rx_exp.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
      else begin
        e = rx_exp.pop_front();
        check("rx_byte", 32'(RxData), 32'(e));
      end
    end
    if (pre_st == IDLE && post_st == RD_OE) grant_log.push_back(1);
    if (pre_st == IDLE && post_st == WR)    grant_log.push_back(2);
    if (pre_st == TURN) check("turn_to_idle", 32'(post_st), 32'(IDLE));
    if (post_st == TURN && pre_st != TURN) begin
      burst_log.push_back(xfer_cnt);
      xfer_cnt = 0;
    end
  endtask

  task automatic wait_state(input sched_state_t s, input string tag);
    bit hit = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (dut.state == s) begin hit = 1; break; end
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  task automatic wait_rd(input int n, input string tag);
    bit hit = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rd_cnt >= n) begin hit = 1; break; end
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  task automatic drain(input string tag);
    bit hit = 0;
    for (int i = 0; i < 400; i++) begin
      if (rx_fifo.size() == 0 && tx_src.size() == 0 && dut.state == IDLE) begin
        hit = 1; break;
      end
      tick();
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    ARst = 1'b1; TXEn = 1'b0; RxReady = 1'b1;
    drive();
    clear_stats();
    #2;
    check("rst_rdn",    32'(RDn), 32'd1);
    check("rst_wrn",    32'(WRn), 32'd1);
    check("rst_oen",    32'(OEn), 32'd1);
    check("rst_douten", 32'(DOutEn), 32'd0);
    check("rst_dout",   32'(DOut), 32'd0);
    check("rst_rxdata", 32'(RxData), 32'd0);
    check("rst_rxvalid",32'(RxValid), 32'd0);
    check("rst_txready",32'(TxReady), 32'd0);
    check("rst_state",  32'(dut.state), 32'(IDLE));
    check("rst_count",  32'(dut.count), 32'd0);
    check("rst_lastrx", 32'(dut.last_rx), 32'd0);
    @(posedge Clk); #1;
    ARst = 1'b0;

    // RX only: three bytes.
    load_rx(8'hA1); load_rx(8'hA2); load_rx(8'hA3);
    drive();
    tick();
    check("rx1_rd_oe", 32'(dut.state), 32'(RD_OE));
    check("rx1_oen",   32'(OEn), 32'd0);
    check("rx1_rdn_oe",32'(RDn), 32'd1);
    tick();
    check("rx1_rd",    32'(dut.state), 32'(RD));
    check("rx1_rdn",   32'(RDn), 32'd0);
    wait_state(TURN, "rx1_to_turn");
    tick();
    check("rx1_idle",  32'(dut.state), 32'(IDLE));
    check("rx1_nvalid",32'(rxv_cnt), 32'd3);
    check("rx1_sb",    32'(rx_exp.size()), 32'd0);

    // TX only: two bytes.
    clear_stats();
    load_tx(8'h55); load_tx(8'h66);
    drive();
    tick();
    check("tx1_wr",     32'(dut.state), 32'(WR));
    check("tx1_douten", 32'(DOutEn), 32'd1);
    wait_state(TURN, "tx1_to_turn");
    tick();
    check("tx1_idle",   32'(dut.state), 32'(IDLE));
    check("tx1_wrn_low",32'(wrn_low_cnt), 32'd2);
    check("tx1_txready",32'(txr_cnt), 32'd2);
    check("tx1_sb",     32'(tx_exp.size()), 32'd0);

    // Contention with bursts capped at MB.
    clear_stats();
    for (int i = 0; i < 12; i++) load_rx(8'(8'h10 + i));
    for (int i = 0; i < 8; i++)  load_tx(8'(8'h80 + i));
    drive();
    drain("ct_drain");
    check("ct_ngrants", 32'(grant_log.size()), 32'd5);
    for (int i = 0; i < grant_log.size() && i < 5; i++) begin
      check("ct_grant", 32'(grant_log[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
      check("ct_burst", 32'(burst_log[i]), 32'(MB));
    end
    check("ct_count_sat", 32'(dut.count), 32'(MB));
    check("ct_rx_sb", 32'(rx_exp.size()), 32'd0);
    check("ct_tx_sb", 32'(tx_exp.size()), 32'd0);

    // Backpressure after byte 2 of 5.
    clear_stats();
    for (int i = 0; i < 5; i++) load_rx(8'(8'hB1 + i));
    drive();
    wait_rd(2, "bp_two");
    RxReady = 1'b0;
    #1;
    check("bp_rdn_high", 32'(RDn), 32'd1);
    tick();
    check("bp_turn", 32'(dut.state), 32'(TURN));
    repeat (4) tick();
    check("bp_hold_idle", 32'(dut.state), 32'(IDLE));
    check("bp_nvalid",    32'(rxv_cnt), 32'd2);
    RxReady = 1'b1;
    drain("bp_drain");
    check("bp_nvalid_all",32'(rxv_cnt), 32'd5);
    check("bp_ngrants",   32'(grant_log.size()), 32'd2);
    check("bp_sb",        32'(rx_exp.size()), 32'd0);

    // TXEn rises mid-burst.
    clear_stats();
    load_tx(8'hC1); load_tx(8'hC2); load_tx(8'hC3);
    drive();
    for (int i = 0; i < 20 && wr_cnt < 1; i++) tick();
    check("te_one", 32'(wr_cnt), 32'd1);
    TXEn = 1'b1;
    #1;
    check("te_txready", 32'(TxReady), 32'd0);
    check("te_wrn",     32'(WRn), 32'd0);
    tick();
    check("te_turn",    32'(dut.state), 32'(TURN));
    repeat (3) tick();
    check("te_idle",    32'(dut.state), 32'(IDLE));
    check("te_nxfer",   32'(wr_cnt), 32'd1);
    TXEn = 1'b0;
    drain("te_drain");
    check("te_nxfer_all", 32'(wr_cnt), 32'd3);
    check("te_sb",        32'(tx_exp.size()), 32'd0);

    // Reset pulse during a read burst.
    clear_stats();
    load_rx(8'hD1); load_rx(8'hD2); load_rx(8'hD3); load_rx(8'hD4);
    drive();
    wait_rd(1, "ar_one");
    check("ar_in_rd", 32'(dut.state), 32'(RD));
    ARst = 1'b1;
    #1;
    check("ar_state",   32'(dut.state), 32'(IDLE));
    check("ar_rdn",     32'(RDn), 32'd1);
    check("ar_oen",     32'(OEn), 32'd1);
    check("ar_rxvalid", 32'(RxValid), 32'd0);
    check("ar_rxdata",  32'(RxData), 32'd0);
    check("ar_count",   32'(dut.count), 32'd0);
    check("ar_lastrx",  32'(dut.last_rx), 32'd0);
    repeat (2) tick();
    ARst = 1'b0;
    xfer_cnt = 0;
    tick();
    check("ar_regrant", 32'(dut.state), 32'(RD_OE));
    drain("ar_drain");
    check("ar_nvalid",  32'(rxv_cnt), 32'd4);
    check("ar_sb",      32'(rx_exp.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
